// File: rtl/gate_id_pkg.sv
// Shared types and constants for the gate identifier: FSM states, gate codes
// and the reference truth tables, indexed as truth[{a,b}].
package gate_id_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    DECODE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] GC_AND     = 3'd0;
  localparam logic [2:0] GC_OR      = 3'd1;
  localparam logic [2:0] GC_NAND    = 3'd2;
  localparam logic [2:0] GC_NOR     = 3'd3;
  localparam logic [2:0] GC_XOR     = 3'd4;
  localparam logic [2:0] GC_XNOR    = 3'd5;
  localparam logic [2:0] GC_UNKNOWN = 3'd7;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  // True when a code names one of the six recognised gates.
  function automatic logic code_is_known(input logic [2:0] code);
    return code <= GC_XNOR;
  endfunction

endpackage

// File: rtl/gate_tt_decoder.sv
// Combinational lookup from a captured 2-input truth table to a gate code;
// anything outside the six known patterns reports unknown.
module gate_tt_decoder
  import gate_id_pkg::*;
(
  input  logic [3:0] truth,
  output logic [2:0] code,
  output logic       valid
);

  always_comb begin
    code = GC_UNKNOWN;
    case (truth)
      TT_AND:  code = GC_AND;
      TT_OR:   code = GC_OR;
      TT_NAND: code = GC_NAND;
      TT_NOR:  code = GC_NOR;
      TT_XOR:  code = GC_XOR;
      TT_XNOR: code = GC_XNOR;
      default: code = GC_UNKNOWN;
    endcase
    valid = code_is_known(code);
  end

endmodule

// File: rtl/gate_identifier.sv
// Characterises an external 2-input gate by walking {a_out,b_out} through all
// four combinations, capturing y_in for each and decoding the truth table.
module gate_identifier
  import gate_id_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_code,
  output logic       valid
);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE);

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [2:0]    dec_code;
  logic          dec_valid;

  gate_tt_decoder u_decoder (
    .truth (truth),
    .code  (dec_code),
    .valid (dec_valid)
  );

  // Each stimulus is held SETTLE+1 cycles; y_in is captured on the edge
  // that closes the window, which is also the edge that moves the stimulus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      truth     <= 4'b0000;
      gate_code <= GC_UNKNOWN;
      valid     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            idx   <= 2'd0;
            cnt   <= '0;
            a_out <= 1'b0;
            b_out <= 1'b0;
            truth <= 4'b0000;
            busy  <= 1'b1;
            state <= DRIVE;
          end
        end

        DRIVE: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            gate_code <= GC_UNKNOWN;
            valid     <= 1'b0;
          end else if (cnt == SETTLE_LAST) begin
            truth[idx] <= y_in;
            cnt        <= '0;
            if (idx == 2'd3) begin
              a_out <= 1'b0;
              b_out <= 1'b0;
              state <= DECODE;
            end else begin
              idx            <= idx + 2'd1;
              {a_out, b_out} <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DECODE: begin
          // Abort still wins here; otherwise publish the result.
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            gate_code <= GC_UNKNOWN;
            valid     <= 1'b0;
          end else begin
            gate_code <= dec_code;
            valid     <= dec_valid;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gate_identifier.md
Name: gate_identifier

Overview:
- Sequential inverse of the mux-built gate bank: this block takes a gate's output and reports which gate function it is.
- Drives an unknown 2-input gate through all four input combinations and captures the gate output for each one.
- Decodes the captured 4-bit truth table into a gate code: AND, OR, NAND, NOR, XOR, XNOR, or unknown.
- Sits beside the gate bank as a self-check / characterisation engine: its a_out/b_out feed the gate under test, and that gate's output returns on y_in.

Parameters:
- SETTLE, 1, cycles each stimulus is held before y_in is sampled; legal range 1..15.
- CW, 4, settle counter width; must satisfy 2^CW > SETTLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a characterisation run; sampled only in IDLE
- abort  input  1  cancel the run in progress
- y_in  input  1  output of the gate under test
- a_out  output  1  stimulus A to the gate under test
- b_out  output  1  stimulus B to the gate under test
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when results update
- truth  output  4  captured outputs; truth[{a,b}] = y_in
- gate_code  output  3  0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 7 unknown
- valid  output  1  gate_code is in 0..5

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - a_out, b_out, busy, done, valid = 0; truth = 4'b0000; gate_code = 3'b111.
- FSM states: IDLE, DRIVE, DECODE, DONE.
- IDLE:
  - start = 1 at a rising edge: idx := 0, settle counter := 0, state -> DRIVE, busy := 1.
  - Otherwise stay in IDLE.
- DRIVE:
  - {a_out, b_out} = idx, registered; the stimulus changes at the same edge that enters or advances DRIVE.
  - Each idx occupies exactly SETTLE+1 cycles.
  - At the edge ending the window, y_in is written into truth[idx].
  - If idx == 3, state -> DECODE; otherwise idx increments and the counter clears.
- DECODE (one cycle):
  - truth 4'b1000 -> 0 (AND), 4'b1110 -> 1 (OR), 4'b0111 -> 2 (NAND), 4'b0001 -> 3 (NOR), 4'b0110 -> 4 (XOR), 4'b1001 -> 5 (XNOR).
  - Any other pattern -> 7, valid = 0.
  - gate_code and valid are registered at the exit edge.
- DONE (one cycle): done = 1, busy = 0; state -> IDLE.
- Latency: from the edge that accepts start, done is high during cycle 4*(SETTLE+1)+2, i.e. 10 with SETTLE = 1.
- truth, gate_code and valid hold their values until the next DECODE. truth is cleared to 0 when start is accepted.
- start while not in IDLE (including the DONE cycle): ignored, no queuing.
- abort = 1 in DRIVE or DECODE:
  - Next edge -> IDLE; busy = 0, no done pulse.
  - a_out/b_out return to 0.
  - gate_code := 7 and valid := 0; truth keeps its partial contents.
- abort and start high together in IDLE: abort has priority, no run starts.
- abort in IDLE or DONE: no effect.
- a_out/b_out are 0 whenever not in DRIVE.
- rst_n asserted mid-run: immediate return to reset values. After release, start is required again.
- y_in is used only at sample edges; its value at all other times is ignored.

Decomposition:
- Package gate_id_pkg:
  - state enum (IDLE, DRIVE, DECODE, DONE);
  - gate code constants (GC_AND ... GC_XNOR, GC_UNKNOWN);
  - truth-table constants (TT_AND = 4'b1000, etc.).
- Sub-module gate_tt_decoder: purely combinational, 4-bit truth table in, 3-bit code plus valid out. It is reused by any future checker.
- The FSM, settle counter and capture register stay in gate_identifier.

Test Plan:
- Gate under test = AND of a_out/b_out, SETTLE = 1, start pulse:
  - truth = 4'b1000, gate_code = 0, valid = 1;
  - done is a single pulse in cycle 10;
  - busy is high for cycles 1-9.
- Loop over OR, NAND, NOR, XOR and XNOR models, each with one cycle of registered delay on y_in: codes 1, 2, 3, 4, 5, valid = 1 in every run.
- Gate under test = constant 1: truth = 4'b1111, gate_code = 7, valid = 0, done still pulses.
- SETTLE = 3, gate under test = XOR delayed 3 cycles: gate_code = 4. Each a_out/b_out value is held exactly 4 cycles; done arrives in cycle 18.
- abort asserted in cycle 5 of an AND run:
  - busy drops in cycle 6, no done pulse;
  - gate_code = 7, valid = 0;
  - a start in cycle 8 completes normally with code 0.
- rst_n pulled low in cycle 3 of a run: all outputs return to reset values asynchronously. A start held high through the run is ignored until IDLE is reached; a fresh start after reset runs normally.
